multicycle_controller: RTL and testbench

- Parametrised multi-cycle control FSM. It is the next-generation replacement for the single-cycle opcode decoder in the processor top.
- Sequences each RV32I-subset instruction (R-type, I-ALU, LW, SW, BEQ) over several states.
- Drives a shared-ALU datapath and handles variable-latency instruction/data memories through req/ready handshakes.
- Provides a watchdog timeout and an illegal-opcode trap; sits beside data_path and ALUController in the processor top.

---
 rtl/mc_pkg.sv | 31 +++
 rtl/mem_wait_timer.sv | 31 +++
 rtl/multicycle_controller.sv | 174 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared opcodes, ALUOp codes and FSM state encoding for the multi-cycle controller.
package mc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // Encodings 12..15 are unreachable and fall into TRAP.
  typedef enum logic [3:0] {
    RST_VEC  = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    ALU_WB   = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    MEM_WB   = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    TRAP     = 4'd11
  } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter: counts stalled request cycles and flags the last allowed one.
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMR_W          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [TMR_W-1:0] count;

  // Clear wins over counting so a fresh wait always starts at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         count <= '0;
    else if (clear)    count <= '0;
    else if (count_en) count <= count + 1'b1;
  end

  // Expired marks the final cycle a request may still see ready; zero disables.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_tmo
      assign expired = (count == TMR_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_tmo
      assign expired = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I-subset control FSM with req/ready memory handshakes,
// watchdog timeout and illegal-opcode trap.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMR_W          = 8,
  parameter bit RESET_PC_LOAD  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem2reg,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       instr_retired,
  output logic       illegal,
  output logic       bus_error,
  output logic       halted
);

  localparam state_t START = RESET_PC_LOAD ? RST_VEC : FETCH;

  state_t state, next_state;
  logic   set_illegal, set_berr, tmr_expired, tmr_clear, tmr_en;

  // Any state change restarts the wait counter; it only runs while stalled.
  assign tmr_clear = (next_state != state);
  assign tmr_en    = (imem_req & ~imem_ready) | (dmem_req & ~dmem_ready);

  mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TMR_W(TMR_W)) u_tmr (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmr_clear),
    .count_en (tmr_en),
    .expired  (tmr_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= START;
    else       state <= next_state;
  end

  // Sticky fault flags, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal   <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      if (set_illegal) illegal   <= 1'b1;
      if (set_berr)    bus_error <= 1'b1;
    end
  end

  // Next-state and control decode; everything is forced low while reset is held
  // so an abandoned instruction leaves no request or write asserted.
  always_comb begin
    next_state    = state;
    set_illegal   = 1'b0;
    set_berr      = 1'b0;
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    reg_write     = 1'b0;
    mem2reg       = 1'b0;
    alu_src       = 1'b0;
    alu_op        = ALUOP_ADD;
    instr_retired = 1'b0;
    halted        = 1'b0;
    if (!reset) begin
      case (state)
        RST_VEC: begin
          pc_write   = 1'b1;
          next_state = FETCH;
        end
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            next_state = DECODE;
          end else if (tmr_expired) begin
            set_berr   = 1'b1;
            next_state = TRAP;
          end
        end
        DECODE: begin
          case (opcode)
            OP_R:               next_state = EXEC_R;
            OP_I:               next_state = EXEC_I;
            OP_LOAD, OP_STORE:  next_state = MEM_ADDR;
            OP_BRANCH:          next_state = BRANCH;
            default: begin
              set_illegal = 1'b1;
              next_state  = TRAP;
            end
          endcase
        end
        EXEC_R: begin
          alu_op     = ALUOP_R;
          next_state = ALU_WB;
        end
        EXEC_I: begin
          alu_src    = 1'b1;
          alu_op     = ALUOP_I;
          next_state = ALU_WB;
        end
        ALU_WB: begin
          reg_write     = 1'b1;
          instr_retired = 1'b1;
          next_state    = FETCH;
        end
        MEM_ADDR: begin
          alu_src    = 1'b1;
          alu_op     = ALUOP_ADD;
          next_state = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          dmem_req = 1'b1;
          if (dmem_ready) begin
            next_state = MEM_WB;
          end else if (tmr_expired) begin
            set_berr   = 1'b1;
            next_state = TRAP;
          end
        end
        MEM_WB: begin
          reg_write     = 1'b1;
          mem2reg       = 1'b1;
          instr_retired = 1'b1;
          next_state    = FETCH;
        end
        MEM_WR: begin
          dmem_req = 1'b1;
          dmem_we  = 1'b1;
          if (dmem_ready) begin
            instr_retired = 1'b1;
            next_state    = FETCH;
          end else if (tmr_expired) begin
            set_berr   = 1'b1;
            next_state = TRAP;
          end
        end
        BRANCH: begin
          alu_op        = ALUOP_SUB;
          pc_src        = 1'b1;
          pc_write      = zero;
          instr_retired = 1'b1;
          next_state    = FETCH;
        end
        TRAP: begin
          halted     = 1'b1;
          next_state = TRAP;
        end
        default: next_state = TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: stimulus pushes the expected output vector of each cycle,
// monitors pop and compare against the DUT outputs.
module tb_multicycle_controller;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  // Output vector bit positions.
  localparam logic [14:0] IREQ = 15'h4000;
  localparam logic [14:0] DREQ = 15'h2000;
  localparam logic [14:0] WE   = 15'h1000;
  localparam logic [14:0] IRW  = 15'h0800;
  localparam logic [14:0] PCW  = 15'h0400;
  localparam logic [14:0] PCS  = 15'h0200;
  localparam logic [14:0] RW   = 15'h0100;
  localparam logic [14:0] M2R  = 15'h0080;
  localparam logic [14:0] ASRC = 15'h0040;
  localparam logic [14:0] A_SUB = 15'h0010;
  localparam logic [14:0] A_R   = 15'h0020;
  localparam logic [14:0] A_I   = 15'h0030;
  localparam logic [14:0] RET  = 15'h0008;
  localparam logic [14:0] ILL  = 15'h0004;
  localparam logic [14:0] BERR = 15'h0002;
  localparam logic [14:0] HALT = 15'h0001;
  localparam logic [14:0] FRDY = IREQ | IRW | PCW;

  typedef struct {
    logic [14:0] exp;
    string       tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic       zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src;
  logic       reg_write, mem2reg, alu_src, instr_retired, illegal, bus_error, halted;
  logic [1:0] alu_op;
  logic [14:0] act;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  event async_chk;

  multicycle_controller #(.TIMEOUT_CYCLES(4), .TMR_W(8), .RESET_PC_LOAD(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .mem2reg(mem2reg), .alu_src(alu_src),
    .alu_op(alu_op), .instr_retired(instr_retired), .illegal(illegal),
    .bus_error(bus_error), .halted(halted)
  );

  assign act = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, reg_write,
                mem2reg, alu_src, alu_op, instr_retired, illegal, bus_error, halted};

  always #5 clk = ~clk;

  task automatic check_head();
    exp_t e;
    e = q.pop_front();
    n_cmp++;
    if (act !== e.exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", e.tag, act, e.exp, $time);
    end
  endtask

  // Per-cycle monitor, sampled mid-cycle.
  always @(negedge clk) if (q.size() > 0) check_head();

  // Out-of-band monitor for the asynchronous reset check.
  always @(async_chk) if (q.size() > 0) check_head();

  // One clock of stimulus plus its expected output vector.
  task automatic cyc(input logic rst, input logic ir, input logic dr, input logic z,
                     input logic [6:0] op, input logic [14:0] e, input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    reset = rst; imem_ready = ir; dmem_ready = dr; zero = z; opcode = op;
    x.exp = e; x.tag = tag;
    q.push_back(x);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    // Reset state
    cyc(1, 0, 0, 0, R, 0, "reset0");
    cyc(1, 1, 1, 0, R, 0, "reset1");
    // R-type, zero-wait fetch
    cyc(0, 1, 0, 0, R, PCW,        "r_rstvec");
    cyc(0, 1, 0, 0, R, FRDY,       "r_fetch");
    cyc(0, 1, 0, 0, R, 0,          "r_decode");
    cyc(0, 1, 0, 0, R, A_R,        "r_exec");
    cyc(0, 1, 0, 0, R, RW | RET,   "r_wb");
    // I-ALU
    cyc(0, 1, 0, 0, I, FRDY,       "i_fetch");
    cyc(0, 1, 0, 0, I, 0,          "i_decode");
    cyc(0, 1, 0, 0, I, ASRC | A_I, "i_exec");
    cyc(0, 1, 0, 0, I, RW | RET,   "i_wb");
    // LW, dmem_ready after 3 wait cycles (ready on last allowed cycle)
    cyc(0, 1, 0, 0, LD, FRDY,      "lw_fetch");
    cyc(0, 1, 0, 0, LD, 0,         "lw_decode");
    cyc(0, 1, 0, 0, LD, ASRC,      "lw_addr");
    cyc(0, 1, 0, 0, LD, DREQ,      "lw_rd0");
    cyc(0, 1, 0, 0, LD, DREQ,      "lw_rd1");
    cyc(0, 1, 0, 0, LD, DREQ,      "lw_rd2");
    cyc(0, 1, 1, 0, LD, DREQ,      "lw_rd3");
    cyc(0, 1, 0, 0, LD, RW | M2R | RET, "lw_wb");
    // SW, zero-wait
    cyc(0, 1, 0, 0, ST, FRDY,      "sw_fetch");
    cyc(0, 1, 1, 0, ST, 0,         "sw_decode");
    cyc(0, 1, 1, 0, ST, ASRC,      "sw_addr");
    cyc(0, 1, 1, 0, ST, DREQ | WE | RET, "sw_wr");
    // BEQ taken then not taken
    cyc(0, 1, 0, 1, BR, FRDY,      "beq1_fetch");
    cyc(0, 1, 0, 1, BR, 0,         "beq1_decode");
    cyc(0, 1, 0, 1, BR, A_SUB | PCS | PCW | RET, "beq1_branch");
    cyc(0, 1, 0, 0, BR, FRDY,      "beq2_fetch");
    cyc(0, 1, 0, 0, BR, 0,         "beq2_decode");
    cyc(0, 1, 0, 0, BR, A_SUB | PCS | RET, "beq2_branch");
    // imem_ready on the 4th fetch cycle: no error
    cyc(0, 0, 0, 0, R, IREQ,       "late_f0");
    cyc(0, 0, 0, 0, R, IREQ,       "late_f1");
    cyc(0, 0, 0, 0, R, IREQ,       "late_f2");
    cyc(0, 1, 0, 0, R, FRDY,       "late_f3");
    cyc(0, 0, 0, 0, R, 0,          "late_decode");
    cyc(0, 0, 0, 0, R, A_R,        "late_exec");
    cyc(0, 0, 0, 0, R, RW | RET,   "late_wb");
    // Fetch timeout
    cyc(0, 0, 0, 0, R, IREQ,       "tmo_f0");
    cyc(0, 0, 0, 0, R, IREQ,       "tmo_f1");
    cyc(0, 0, 0, 0, R, IREQ,       "tmo_f2");
    cyc(0, 0, 0, 0, R, IREQ,       "tmo_f3");
    cyc(0, 0, 0, 0, R, HALT | BERR, "tmo_trap");
    cyc(0, 1, 1, 0, R, HALT | BERR, "tmo_stuck0");
    cyc(0, 1, 1, 0, R, HALT | BERR, "tmo_stuck1");
    cyc(1, 1, 0, 0, R, 0,          "tmo_reset");
    // Illegal opcode
    cyc(0, 1, 0, 0, BAD, PCW,      "ill_rstvec");
    cyc(0, 1, 0, 0, BAD, FRDY,     "ill_fetch");
    cyc(0, 1, 0, 0, BAD, 0,        "ill_decode");
    cyc(0, 1, 0, 0, R, HALT | ILL, "ill_trap");
    cyc(0, 1, 1, 0, R, HALT | ILL, "ill_stuck0");
    cyc(0, 1, 1, 0, LD, HALT | ILL, "ill_stuck1");
    cyc(1, 1, 0, 0, R, 0,          "ill_reset");
    // Reset asserted during MEM_WR
    cyc(0, 1, 0, 0, ST, PCW,       "rw_rstvec");
    cyc(0, 1, 0, 0, ST, FRDY,      "rw_fetch");
    cyc(0, 1, 0, 0, ST, 0,         "rw_decode");
    cyc(0, 1, 0, 0, ST, ASRC,      "rw_addr");
    cyc(0, 1, 0, 0, ST, DREQ | WE, "rw_wr0");
    cyc(0, 1, 0, 0, ST, DREQ | WE, "rw_wr1");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    x.exp = 0; x.tag = "rw_async_drop";
    q.push_back(x);
    -> async_chk;
    cyc(1, 0, 0, 0, ST, 0,         "rw_reset_held");
    cyc(0, 0, 0, 0, ST, PCW,       "rw_after_rstvec");
    cyc(0, 0, 0, 0, ST, IREQ,      "rw_after_fetch");
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
